bus_arb2: RTL and testbench

BUS_ARB2 -- requirements
Module: bus_arb2

---
 rtl/bus_arb2.sv | 147 ++++++++++++++
 tb/tb_bus_arb2.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arb2.sv
// Two-master round-robin bus arbiter: m0 is the CPU data port and m1 is the DMA data port.
// It forwards one request at a time to a single slave and applies a response timeout.
module bus_arb2 #(
  parameter int unsigned TOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // m0: CPU data port
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_size,
  input  logic        m0_write,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  // m1: DMA data port
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_size,
  input  logic        m1_write,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  // slave side
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [1:0]  s_size,
  output logic        s_write,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [7:0]  TLIM      = 8'(TOUT - 1);
  localparam logic [31:0] TOUT_DATA = 32'hDEAD_BEEF;

  state_t      state, state_nxt;
  logic        lg, lg_nxt;
  logic [7:0]  cnt, cnt_nxt;

  logic        g1;
  logic        gv;
  logic        done_rdy;
  logic        done_err;
  logic [31:0] done_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lg    <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      lg    <= lg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lg_nxt    = lg;
    cnt_nxt   = cnt;
    g1        = (state == BUSY1);
    gv        = g1 ? m1_valid : m0_valid;
    done_rdy  = 1'b0;
    done_err  = 1'b0;
    done_data = '0;
    s_valid   = 1'b0;
    s_addr    = '0;
    s_size    = '0;
    s_write   = 1'b0;
    s_wdata   = '0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (m0_valid && m1_valid) begin
          state_nxt = lg ? BUSY0 : BUSY1;
          lg_nxt    = ~lg;
        end else if (m0_valid) begin
          state_nxt = BUSY0;
          lg_nxt    = 1'b0;
        end else if (m1_valid) begin
          state_nxt = BUSY1;
          lg_nxt    = 1'b1;
        end
      end

      BUSY0, BUSY1: begin
        s_valid = gv;
        s_addr  = g1 ? m1_addr  : m0_addr;
        s_size  = g1 ? m1_size  : m0_size;
        s_write = g1 ? m1_write : m0_write;
        s_wdata = g1 ? m1_wdata : m0_wdata;
        // Abort beats both completion paths; s_ready beats the timeout.
        if (!gv) begin
          state_nxt = IDLE;
        end else if (s_ready) begin
          done_rdy  = 1'b1;
          done_data = s_rdata;
          state_nxt = IDLE;
        end else if (cnt == TLIM) begin
          s_valid   = 1'b0;
          done_rdy  = 1'b1;
          done_err  = 1'b1;
          done_data = TOUT_DATA;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    m0_ready = done_rdy & ~g1;
    m0_err   = done_err & ~g1;
    m0_rdata = g1 ? '0 : done_data;
    m1_ready = done_rdy & g1;
    m1_err   = done_err & g1;
    m1_rdata = g1 ? done_data : '0;

    // Outputs are forced quiet while reset is held, even mid-transfer.
    if (rst) begin
      m0_ready = 1'b0;
      m0_err   = 1'b0;
      m0_rdata = '0;
      m1_ready = 1'b0;
      m1_err   = 1'b0;
      m1_rdata = '0;
      s_valid  = 1'b0;
      s_addr   = '0;
      s_size   = '0;
      s_write  = 1'b0;
      s_wdata  = '0;
    end
  end

endmodule

// File: tb/tb_bus_arb2.sv
// Directed cycle-table bench for bus_arb2 (TOUT=4), followed by a few hand-written
// multi-cycle sequences.
module tb_bus_arb2;

  localparam logic [31:0] A0  = 32'h0000_0100;
  localparam logic [31:0] W0  = 32'h1111_2222;
  localparam logic [31:0] A1  = 32'h2000_0004;
  localparam logic [31:0] W1  = 32'hA5A5_A5A5;
  localparam logic [31:0] RD  = 32'h1234_5678;
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;
  localparam logic [31:0] ZZ  = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [1:0]  m0_size, m1_size;
  logic        m0_write, m1_write;
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_write, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  s_size;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arb2 #(.TOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_size(m0_size), .m0_write(m0_write),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_size(m1_size), .m1_write(m1_write),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_size(s_size), .s_write(s_write),
    .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  typedef struct {
    logic        rst, m0v, m1v, sr;
    logic        sv;
    logic [1:0]  src;   // 0: slave fields zero, 1: from m0, 2: from m1
    logic        r0, e0;
    logic [31:0] d0;
    logic        r1, e1;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v0, input logic v1, input logic sr,
                     input logic sv, input logic [1:0] src,
                     input logic r0, input logic e0, input logic [31:0] d0,
                     input logic r1, input logic e1, input logic [31:0] d1);
    vec_t v;
    v.rst = r; v.m0v = v0; v.m1v = v1; v.sr = sr; v.sv = sv; v.src = src;
    v.r0 = r0; v.e0 = e0; v.d0 = d0; v.r1 = r1; v.e1 = e1; v.d1 = d1;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step %0d got=%h exp=%h", nm, idx, got, exp);
    end
  endtask

  task automatic check_row(input int i, input vec_t v);
    logic [31:0] ea, ew;
    logic [1:0]  es;
    logic        ewr;
    case (v.src)
      2'd1:    begin ea = A0; es = 2'd2; ewr = 1'b0; ew = W0; end
      2'd2:    begin ea = A1; es = 2'd2; ewr = 1'b1; ew = W1; end
      default: begin ea = ZZ; es = 2'd0; ewr = 1'b0; ew = ZZ; end
    endcase
    chk("s_valid", i, 32'(s_valid), 32'(v.sv));
    chk("s_addr",  i, s_addr, ea);
    chk("s_size",  i, 32'(s_size), 32'(es));
    chk("s_write", i, 32'(s_write), 32'(ewr));
    chk("s_wdata", i, s_wdata, ew);
    chk("m0_ready", i, 32'(m0_ready), 32'(v.r0));
    chk("m0_err",   i, 32'(m0_err), 32'(v.e0));
    chk("m0_rdata", i, m0_rdata, v.d0);
    chk("m1_ready", i, 32'(m1_ready), 32'(v.r1));
    chk("m1_err",   i, 32'(m1_err), 32'(v.e1));
    chk("m1_rdata", i, m1_rdata, v.d1);
  endtask

  initial begin
    int svcnt;
    int hit;
    rst = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    m0_addr = A0; m0_size = 2'd2; m0_write = 1'b0; m0_wdata = W0;
    m1_addr = A1; m1_size = 2'd2; m1_write = 1'b1; m1_wdata = W1;
    s_rdata = RD;

    //   rst m0v m1v sr | sv src | r0 e0 d0 | r1 e1 d1
    add(1, 0, 0, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 0 reset
    add(1, 1, 1, 1,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 1 reset ignores inputs
    add(0, 0, 0, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 2 idle after reset
    add(0, 1, 0, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 3 m0 read request
    add(0, 1, 0, 0,  1, 1,  0, 0, ZZ,  0, 0, ZZ);  // 4 busy0 #1
    add(0, 1, 0, 0,  1, 1,  0, 0, ZZ,  0, 0, ZZ);  // 5 busy0 #2
    add(0, 1, 0, 1,  1, 1,  1, 0, RD,  0, 0, ZZ);  // 6 slave ready
    add(0, 0, 0, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 7 idle
    add(1, 0, 0, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 8 reset -> lg=1
    add(0, 1, 1, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 9 tie -> m0
    add(0, 1, 1, 1,  1, 1,  1, 0, RD,  0, 0, ZZ);  // 10
    add(0, 1, 1, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 11 tie -> m1
    add(0, 1, 1, 1,  1, 2,  0, 0, ZZ,  1, 0, RD);  // 12
    add(0, 1, 1, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 13 tie -> m0
    add(0, 1, 1, 1,  1, 1,  1, 0, RD,  0, 0, ZZ);  // 14
    add(0, 1, 1, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 15 tie -> m1
    add(0, 1, 1, 1,  1, 2,  0, 0, ZZ,  1, 0, RD);  // 16
    add(0, 0, 1, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 17 DMA write request
    add(0, 0, 1, 0,  1, 2,  0, 0, ZZ,  0, 0, ZZ);  // 18
    add(0, 1, 1, 0,  1, 2,  0, 0, ZZ,  0, 0, ZZ);  // 19 m0 waits, sees zeros
    add(0, 0, 0, 1,  0, 2,  0, 0, ZZ,  0, 0, ZZ);  // 20 m1 abort, no ready
    add(0, 0, 0, 1,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 21 s_ready ignored in idle
    add(0, 1, 0, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 22 m0 request
    add(0, 1, 0, 0,  1, 1,  0, 0, ZZ,  0, 0, ZZ);  // 23 busy #1
    add(0, 1, 0, 0,  1, 1,  0, 0, ZZ,  0, 0, ZZ);  // 24 busy #2
    add(0, 1, 0, 0,  1, 1,  0, 0, ZZ,  0, 0, ZZ);  // 25 busy #3
    add(0, 1, 0, 0,  0, 1,  1, 1, DB,  0, 0, ZZ);  // 26 busy #4 timeout
    add(0, 1, 0, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 27 new request
    add(0, 1, 0, 0,  1, 1,  0, 0, ZZ,  0, 0, ZZ);  // 28
    add(0, 1, 0, 0,  1, 1,  0, 0, ZZ,  0, 0, ZZ);  // 29
    add(0, 1, 0, 0,  1, 1,  0, 0, ZZ,  0, 0, ZZ);  // 30
    add(0, 1, 0, 1,  1, 1,  1, 0, RD,  0, 0, ZZ);  // 31 s_ready wins over timeout
    add(0, 1, 0, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 32 request
    add(0, 1, 0, 0,  1, 1,  0, 0, ZZ,  0, 0, ZZ);  // 33 busy0
    add(1, 1, 0, 1,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 34 reset mid-transfer
    add(0, 1, 0, 1,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 35 idle after reset
    add(0, 1, 0, 1,  1, 1,  1, 0, RD,  0, 0, ZZ);  // 36
    add(0, 0, 0, 0,  0, 0,  0, 0, ZZ,  0, 0, ZZ);  // 37

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; m0_valid = tbl[i].m0v; m1_valid = tbl[i].m1v; s_ready = tbl[i].sr;
      #2;
      check_row(i, tbl[i]);
      @(posedge clk); #1;
    end

    // m1 timeout: request in idle, ready+err expected on the 4th busy cycle
    m1_valid = 1'b1; s_ready = 1'b0;
    hit = -1;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (m1_ready) begin
        hit = k;
        chk("m1_to_err", k, 32'(m1_err), 32'd1);
        chk("m1_to_rdata", k, m1_rdata, DB);
        chk("m1_to_svalid", k, 32'(s_valid), 32'd0);
        chk("m1_to_m0ready", k, 32'(m0_ready), 32'd0);
      end
      @(posedge clk); #1;
      if (hit >= 0) break;
    end
    chk("m1_to_cycle", 100, 32'(hit), 32'd4);
    m1_valid = 1'b0;
    #2;
    chk("m1_to_idle", 101, 32'(s_valid), 32'd0);
    @(posedge clk); #1;

    // m0 read with slave ready on the third s_valid cycle: s_valid high for exactly 3 cycles
    m0_valid = 1'b1;
    svcnt = 0; hit = -1;
    for (int k = 0; k < 10; k++) begin
      s_ready = (k == 3);
      #2;
      if (s_valid) svcnt++;
      if (m0_ready) begin
        hit = k;
        chk("rd_rdata", k, m0_rdata, RD);
        chk("rd_err", k, 32'(m0_err), 32'd0);
      end
      @(posedge clk); #1;
      if (hit >= 0) break;
    end
    chk("rd_ready_cycle", 102, 32'(hit), 32'd3);
    chk("rd_svalid_cycles", 103, 32'(svcnt), 32'd3);
    m0_valid = 1'b0; s_ready = 1'b0;
    #2;
    chk("rd_ready_pulse", 104, 32'(m0_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
